// File: rtl/dbg_cmd_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_cmd_bridge_if                                               |
// | Purpose  : Receive strobe, transmit handshake and register bus of the      |
// |            debug command bridge.                                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface dbg_cmd_bridge_if #(
    parameter int ADDR_W = 4
);
    logic              rcv;
    logic [7:0]        rxdata;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              ovf;

    // master is the bridge itself; slave is the receiver/transmitter/register side
    modport master (
        input  rcv, rxdata, tx_ready, reg_rdata,
        output tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, ovf
    );

    modport slave (
        output rcv, rxdata, tx_ready, reg_rdata,
        input  tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dbg_cmd_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_cmd_bridge                                                  |
// | Purpose  : Framed 1-3 byte command decoder driving a local register bus    |
// |            and returning one response byte per frame.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dbg_cmd_bridge #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    dbg_cmd_bridge_if.master  bus
);

    localparam int              c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_MAX = c_CNT_W'(TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_TMO_ONE = c_CNT_W'(1);

    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_PING  = 8'h50;
    localparam logic [7:0] c_RSP_OK   = 8'h4B;
    localparam logic [7:0] c_RSP_ACK  = 8'h41;
    localparam logic [7:0] c_RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_SEND     = 3'd4,
        S_WAIT_LO  = 3'd5,
        S_WAIT_HI  = 3'd6
    } state_t;

    state_t               r_state,     w_state;
    logic                 r_is_write,  w_is_write;
    logic                 r_addr_ok,   w_addr_ok;
    logic [c_CNT_W-1:0]   r_tmo_cnt,   w_tmo_cnt;
    logic                 r_tx_start,  w_tx_start;
    logic [7:0]           r_tx_data,   w_tx_data;
    logic [ADDR_W-1:0]    r_reg_addr,  w_reg_addr;
    logic [7:0]           r_reg_wdata, w_reg_wdata;
    logic                 r_reg_we,    w_reg_we;
    logic                 r_reg_re,    w_reg_re;
    logic                 r_busy,      w_busy;
    logic                 r_ovf,       w_ovf;

    logic                 w_rx_addr_ok;
    logic [c_CNT_W-1:0]   w_tmo_inc;
    logic                 w_tmo_expired;

    // An address byte is legal only if no bit at or above ADDR_W is set.
    assign w_rx_addr_ok  = ((bus.rxdata >> ADDR_W) == 8'h00);
    assign w_tmo_inc     = (r_tmo_cnt == c_TMO_MAX) ? r_tmo_cnt : (r_tmo_cnt + c_TMO_ONE);
    assign w_tmo_expired = (w_tmo_inc == c_TMO_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_addr_ok   <= 1'b0;
            r_tmo_cnt   <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_is_write  <= w_is_write;
            r_addr_ok   <= w_addr_ok;
            r_tmo_cnt   <= w_tmo_cnt;
            r_tx_start  <= w_tx_start;
            r_tx_data   <= w_tx_data;
            r_reg_addr  <= w_reg_addr;
            r_reg_wdata <= w_reg_wdata;
            r_reg_we    <= w_reg_we;
            r_reg_re    <= w_reg_re;
            r_busy      <= w_busy;
            r_ovf       <= w_ovf;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_is_write  = r_is_write;
        w_addr_ok   = r_addr_ok;
        w_tmo_cnt   = '0;
        w_tx_start  = 1'b0;
        w_tx_data   = r_tx_data;
        w_reg_addr  = r_reg_addr;
        w_reg_wdata = r_reg_wdata;
        w_reg_we    = 1'b0;
        w_reg_re    = 1'b0;
        w_ovf       = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (bus.rcv) begin
                    case (bus.rxdata)
                        c_OP_READ: begin
                            w_is_write = 1'b0;
                            w_state    = S_GET_ADDR;
                        end
                        c_OP_WRITE: begin
                            w_is_write = 1'b1;
                            w_state    = S_GET_ADDR;
                        end
                        c_OP_PING: begin
                            w_tx_data = c_RSP_ACK;
                            w_state   = S_SEND;
                        end
                        default: begin
                            w_tx_data = c_RSP_ERR;
                            w_state   = S_SEND;
                        end
                    endcase
                end
            end

            S_GET_ADDR: begin
                if (bus.rcv) begin
                    w_reg_addr = bus.rxdata[ADDR_W-1:0];
                    w_addr_ok  = w_rx_addr_ok;
                    if (r_is_write) begin
                        w_state = S_GET_DATA;
                    end else begin
                        w_reg_re = w_rx_addr_ok;
                        w_state  = S_RD_WAIT;
                    end
                end else begin
                    w_tmo_cnt = w_tmo_inc;
                    if (w_tmo_expired) begin
                        w_state = S_IDLE;
                    end
                end
            end

            S_GET_DATA: begin
                if (bus.rcv) begin
                    w_reg_wdata = bus.rxdata;
                    w_reg_we    = r_addr_ok;
                    w_tx_data   = r_addr_ok ? c_RSP_OK : c_RSP_ERR;
                    w_state     = S_SEND;
                end else begin
                    w_tmo_cnt = w_tmo_inc;
                    if (w_tmo_expired) begin
                        w_state = S_IDLE;
                    end
                end
            end

            // First cycle carries reg_re; read data is valid only in the cycle after it.
            S_RD_WAIT: begin
                if (bus.rcv) begin
                    w_ovf = 1'b1;
                end
                if (!r_reg_re) begin
                    w_tx_data = r_addr_ok ? bus.reg_rdata : c_RSP_ERR;
                    w_state   = S_SEND;
                end
            end

            S_SEND: begin
                if (bus.rcv) begin
                    w_ovf = 1'b1;
                end
                if (bus.tx_ready) begin
                    w_tx_start = 1'b1;
                    w_state    = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (bus.rcv) begin
                    w_ovf = 1'b1;
                end
                if (!bus.tx_ready) begin
                    w_state = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (bus.rcv) begin
                    w_ovf = 1'b1;
                end
                if (bus.tx_ready) begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_re    = r_reg_re;
    assign bus.busy      = r_busy;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
